fft_band_analyzer: RTL and testbench

FFT_BAND_ANALYZER -- requirements
Module: fft_band_analyzer

---
 rtl/fft_band_analyzer_if.sv | 11 +
 rtl/fft_band_analyzer.sv | 198 +++++++++++++++++++
 tb/tb_fft_band_analyzer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_band_analyzer_if.sv
// Sample stream into the band analyser: valid/ready handshake carrying offset-binary audio samples.
interface fft_band_analyzer_if #(
  parameter int SW = 8
) ();
  logic          s_valid;
  logic [SW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fft_band_analyzer.sv
// Frame-based audio band analyser: captures N samples, runs an in-place radix-2 DIT FFT
// (one butterfly per cycle), then folds bin powers into BANDS 8-bit band levels.
module fft_band_analyzer #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int SW    = 8,
  parameter int DW    = 16,
  parameter int BANDS = 8,
  parameter int PSH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_band_analyzer_if.slave   s,
  input  logic                 mode,
  input  logic                 freeze,
  output logic [8*BANDS-1:0]   band_pwr,
  output logic                 frame_done
);
  localparam int  HW    = DW / 2;
  localparam int  BSH   = $clog2(N / 2 / BANDS);
  localparam int  STW   = $clog2(LOG2N);
  localparam int  SCALE = (1 << (HW - 1)) - 1;
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic [1:0] {S_CAPTURE, S_FFT, S_MAG, S_DONE} state_e;

  // Twiddle table for W^k, k < N/2; the imaginary table already holds -sin.
  function automatic logic [N/2*HW-1:0] build_rom(input bit imag);
    logic [N/2*HW-1:0] rom;
    real ang, val;
    int  q;
    rom = '0;
    for (int k = 0; k < N / 2; k++) begin
      ang = 2.0 * PI * real'(k) / real'(N);
      val = imag ? -$sin(ang) * real'(SCALE) : $cos(ang) * real'(SCALE);
      q   = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
      rom[k*HW +: HW] = HW'(q);
    end
    return rom;
  endfunction

  localparam logic [N/2*HW-1:0] COS_ROM = build_rom(1'b0);
  localparam logic [N/2*HW-1:0] SIN_ROM = build_rom(1'b1);

  state_e                    state_q, state_d;
  logic [LOG2N-1:0]          cnt_q, cnt_d;
  logic [STW-1:0]            stage_q, stage_d;
  logic                      mode_q, mode_d;
  logic [BANDS-1:0][7:0]     acc_q, acc_d;
  logic [BANDS-1:0][7:0]     band_q, band_d;
  logic                      done_q, done_d;
  logic [DW-1:0]             ram_q [N];

  logic [LOG2N-1:0]          pp, mask, jj, idx_a, idx_b, cap_addr, mag_addr;
  logic [STW-1:0]            tsh;
  logic [LOG2N-2:0]          tw_k;
  logic signed [HW-1:0]      a_re, a_im, b_re, b_im, w_re, w_im, m_re, m_im;
  logic signed [2*HW:0]      pr, pi, sq_re, sq_im;
  logic signed [HW+1:0]      t_re, t_im, s1_re, s1_im, s2_re, s2_im;
  logic [DW:0]               pwr, pwr_sh;
  logic [7:0]                mag_v;
  logic [8:0]                sum9;
  logic                      we_a, we_b;
  logic [LOG2N-1:0]          wa_addr;
  logic [DW-1:0]             wa_data, wb_data, cap_word;

  // Butterfly pair and twiddle index for the current stage/pair counter.
  always_comb begin
    pp    = {1'b0, cnt_q[LOG2N-2:0]};
    mask  = (LOG2N'(1) << stage_q) - LOG2N'(1);
    jj    = pp & mask;
    idx_a = ((pp & ~mask) << 1) | jj;
    idx_b = idx_a | (LOG2N'(1) << stage_q);
    tsh   = STW'(LOG2N - 1) - stage_q;
    tw_k  = (LOG2N-1)'(jj << tsh);
    for (int i = 0; i < LOG2N; i++) cap_addr[i] = cnt_q[LOG2N-1-i];
    mag_addr = cnt_q + LOG2N'(1);
    cap_word = {HW'({~s.s_data[SW-1], s.s_data[SW-2:0]}) << (HW - SW), HW'(0)};
  end

  always_comb begin
    a_re  = ram_q[idx_a][DW-1:HW];
    a_im  = ram_q[idx_a][HW-1:0];
    b_re  = ram_q[idx_b][DW-1:HW];
    b_im  = ram_q[idx_b][HW-1:0];
    w_re  = COS_ROM[int'(tw_k)*HW +: HW];
    w_im  = SIN_ROM[int'(tw_k)*HW +: HW];
    pr    = b_re * w_re - b_im * w_im;
    pi    = b_re * w_im + b_im * w_re;
    t_re  = (HW+2)'(pr >>> (HW - 1));
    t_im  = (HW+2)'(pi >>> (HW - 1));
    s1_re = a_re + t_re;
    s1_im = a_im + t_im;
    s2_re = a_re - t_re;
    s2_im = a_im - t_im;
    m_re  = ram_q[mag_addr][DW-1:HW];
    m_im  = ram_q[mag_addr][HW-1:0];
    sq_re = m_re * m_re;
    sq_im = m_im * m_im;
    pwr    = DW'(0) + $unsigned(sq_re[DW:0]) + $unsigned(sq_im[DW:0]);
    pwr_sh = pwr >> PSH;
    mag_v  = (|pwr_sh[DW:8]) ? 8'hFF : pwr_sh[7:0];
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    band_d  = band_q;
    done_d  = 1'b0;
    sum9    = '0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    wa_addr = cap_addr;
    wa_data = cap_word;
    wb_data = {HW'(s2_re >>> 1), HW'(s2_im >>> 1)};
    case (state_q)
      S_CAPTURE: begin
        acc_d = '0;
        if (s.s_valid) begin
          we_a  = 1'b1;
          cnt_d = cnt_q + LOG2N'(1);
          if (cnt_q == LOG2N'(N - 1)) begin
            state_d = S_FFT;
            mode_d  = mode;
            stage_d = '0;
          end
        end
      end
      S_FFT: begin
        we_a    = 1'b1;
        we_b    = 1'b1;
        wa_addr = idx_a;
        wa_data = {HW'(s1_re >>> 1), HW'(s1_im >>> 1)};
        if (&cnt_q[LOG2N-2:0]) begin
          cnt_d = '0;
          if (stage_q == STW'(LOG2N - 1)) state_d = S_MAG;
          else                            stage_d = stage_q + STW'(1);
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      S_MAG: begin
        for (int b = 0; b < BANDS; b++) begin
          if ((int'(cnt_q) >> BSH) == b) begin
            sum9     = {1'b0, acc_q[b]} + {1'b0, mag_v};
            acc_d[b] = mode_q ? ((mag_v > acc_q[b]) ? mag_v : acc_q[b])
                              : (sum9[8] ? 8'hFF : sum9[7:0]);
          end
        end
        cnt_d = cnt_q + LOG2N'(1);
        if (cnt_q == LOG2N'(N / 2 - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        if (!freeze) band_d = acc_q;
        state_d = S_CAPTURE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CAPTURE;
      cnt_q   <= '0;
      stage_q <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      band_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      band_q  <= band_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the sample RAM is never reset; every word is rewritten by capture before it is read.
  always_ff @(posedge clk) begin
    if (we_a) ram_q[wa_addr] <= wa_data;
    if (we_b) ram_q[idx_b]   <= wb_data;
  end

  assign s.s_ready  = (state_q == S_CAPTURE);
  assign band_pwr   = band_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_fft_band_analyzer.sv
// Directed bench for fft_band_analyzer: vector table of test frames checked against an
// integer FFT reference, plus reset and mid-frame abort sequences.
module tb_fft_band_analyzer;
  localparam real PI = 3.14159265358979323846;

  typedef enum int {W_DC, W_TONE4, W_TWO, W_SQ} wave_e;
  typedef struct {
    wave_e wave;
    bit    md;
    bit    fz;
    int    band;       // band to range-check, -1 for none
    int    lo;
    int    hi;
    int    other_max;
  } vec_t;

  logic        clk, rst, mode, freeze, frame_done;
  logic [63:0] band_pwr;
  int          n_cmp, n_fail, acc_cnt;
  int          smp [32];
  int          tw_re [16];
  int          tw_im [16];

  fft_band_analyzer_if #(.SW(8)) s_if ();

  fft_band_analyzer #(.N(32), .LOG2N(5), .SW(8), .DW(16), .BANDS(8), .PSH(4)) dut (
    .clk(clk), .rst(rst), .s(s_if), .mode(mode), .freeze(freeze),
    .band_pwr(band_pwr), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (s_if.s_valid && s_if.s_ready) acc_cnt <= acc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int bitrev5(input int v);
    int r = 0;
    for (int i = 0; i < 5; i++) if (((v >> i) & 1) != 0) r |= 1 << (4 - i);
    return r;
  endfunction

  task automatic fill(input wave_e w);
    for (int n = 0; n < 32; n++) begin
      case (w)
        W_DC:    smp[n] = 128;
        W_TONE4: smp[n] = 128 + rnd(127.0 * $cos(2.0 * PI * 4.0 * n / 32.0));
        W_TWO:   smp[n] = 128 + rnd(63.0 * $cos(2.0 * PI * 3.0 * n / 32.0))
                              + rnd(63.0 * $cos(2.0 * PI * 4.0 * n / 32.0));
        default: smp[n] = 128 + (((n % 8) < 4) ? 110 : -110)
                              + rnd(17.0 * $cos(2.0 * PI * 3.0 * n / 32.0));
      endcase
    end
  endtask

  // Reference: bit-reversed load, stage-by-stage butterflies, then band folding.
  function automatic logic [63:0] model(input bit md);
    int re [32];
    int im [32];
    int band [8];
    logic [63:0] r;
    for (int n = 0; n < 32; n++) begin
      re[bitrev5(n)] = smp[n] - 128;
      im[bitrev5(n)] = 0;
    end
    for (int s = 0; s < 5; s++) begin
      int half = 1 << s;
      for (int base = 0; base < 32; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          int a  = base + j;
          int b  = a + half;
          int k  = j * (16 / half);
          int tr = (re[b] * tw_re[k] - im[b] * tw_im[k]) >>> 7;
          int ti = (re[b] * tw_im[k] + im[b] * tw_re[k]) >>> 7;
          int ar = re[a];
          int ai = im[a];
          re[a] = (ar + tr) >>> 1;
          im[a] = (ai + ti) >>> 1;
          re[b] = (ar - tr) >>> 1;
          im[b] = (ai - ti) >>> 1;
        end
      end
    end
    for (int b = 0; b < 8; b++) band[b] = 0;
    for (int bin = 1; bin <= 16; bin++) begin
      int v  = (re[bin] * re[bin] + im[bin] * im[bin]) >>> 4;
      int bi = (bin - 1) / 2;
      if (v > 255) v = 255;
      if (md) band[bi] = (v > band[bi]) ? v : band[bi];
      else    band[bi] = (band[bi] + v > 255) ? 255 : band[bi] + v;
    end
    for (int b = 0; b < 8; b++) r[8*b +: 8] = 8'(band[b]);
    return r;
  endfunction

  // Offer smp[] with s_valid held high; returns once the 32nd accepting edge has passed.
  task automatic feed(input bit md, output bit ok);
    int k = 0;
    int guard = 0;
    mode = md;
    while (k < 32 && guard < 400) begin
      @(negedge clk);
      guard++;
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'(smp[k]);
      if (s_if.s_ready) k++;
    end
    ok = (k == 32);
    if (ok) @(posedge clk);
  endtask

  task automatic run_frame(input bit md, input bit fz, input logic [63:0] prev,
                           input logic [63:0] exp, input string tag);
    int  c = 0;
    int  rdy_low = 0;
    int  acc0;
    bit  seen = 1'b0;
    bit  stable = 1'b1;
    bit  ok;
    acc0   = acc_cnt;
    freeze = fz;
    feed(md, ok);
    check({tag, "_feed_ok"}, 64'(ok), 64'd1);
    #1;
    mode        = ~md;
    s_if.s_data = 8'hA5;
    while (!seen && c < 200) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else begin
        if (!s_if.s_ready) rdy_low++;
        if (band_pwr !== prev) stable = 1'b0;
        c++;
      end
    end
    s_if.s_valid = 1'b0;
    check({tag, "_latency"}, 64'(c), 64'd97);
    check({tag, "_ready_low"}, 64'(rdy_low), 64'd97);
    check({tag, "_accepts"}, 64'(acc_cnt - acc0), 64'd32);
    check({tag, "_stable"}, 64'(stable), 64'd1);
    check({tag, "_bands"}, band_pwr, exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    vec_t        vecs [8];
    logic [63:0] cur, exp;
    int          other, quiet;
    bit          ok;

    vecs[0] = '{W_DC,    1'b0, 1'b0,  0,   0,   0,   0};
    vecs[1] = '{W_TONE4, 1'b0, 1'b0,  1, 240, 255,   4};
    vecs[2] = '{W_TWO,   1'b0, 1'b0, -1,   0, 255, 255};
    vecs[3] = '{W_TONE4, 1'b1, 1'b1, -1,   0, 255, 255};
    vecs[4] = '{W_TWO,   1'b1, 1'b0, -1,   0, 255, 255};
    vecs[5] = '{W_SQ,    1'b0, 1'b0,  1, 255, 255, 255};
    vecs[6] = '{W_SQ,    1'b1, 1'b0,  1, 255, 255, 255};
    vecs[7] = '{W_TONE4, 1'b1, 1'b0,  1, 240, 255,   4};

    n_cmp = 0; n_fail = 0; acc_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tw_re[k] = rnd($cos(2.0 * PI * real'(k) / 32.0) * 127.0);
      tw_im[k] = rnd(-$sin(2.0 * PI * real'(k) / 32.0) * 127.0);
    end

    rst = 1'b1; mode = 1'b0; freeze = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_band_pwr", band_pwr, 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_s_ready", 64'(s_if.s_ready), 64'd1);
    rst = 1'b0;

    cur = '0;
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].wave);
      exp = vecs[i].fz ? cur : model(vecs[i].md);
      run_frame(vecs[i].md, vecs[i].fz, cur, exp, $sformatf("vec%0d", i));
      if (vecs[i].band >= 0) begin
        check_range($sformatf("vec%0d_target_band", i),
                    int'(band_pwr[8*vecs[i].band +: 8]), vecs[i].lo, vecs[i].hi);
        other = 0;
        for (int b = 0; b < 8; b++)
          if (b != vecs[i].band && int'(band_pwr[8*b +: 8]) > other) other = int'(band_pwr[8*b +: 8]);
        check_range($sformatf("vec%0d_other_bands", i), other, 0, vecs[i].other_max);
      end
      cur = exp;
    end

    // Abort a frame with reset 40 cycles into the FFT.
    fill(W_TONE4);
    freeze = 1'b0;
    feed(1'b0, ok);
    check("abort_feed_ok", 64'(ok), 64'd1);
    s_if.s_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_band_pwr", band_pwr, 64'd0);
    check("abort_s_ready", 64'(s_if.s_ready), 64'd1);
    quiet = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (frame_done) quiet++;
    end
    check("abort_no_done", 64'(quiet), 64'd0);
    check("abort_band_hold", band_pwr, 64'd0);
    fill(W_TONE4);
    run_frame(1'b0, 1'b0, 64'd0, model(1'b0), "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
